// File: rtl/uart_calc_sequencer_pkg.sv
// Shared types and constants for the UART -> adder -> UART sequencer.
package uart_calc_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int CLK_HZ        = 100_000_000;
  localparam int BAUD          = 115_200;
  localparam int BAUD_PRESCALE = CLK_HZ / (BAUD * 8);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_B = 3'd1,
    CALC   = 3'd2,
    TX_HI  = 3'd3,
    TX_LO  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/uart_calc_sequencer_if.sv
// RX stream, TX stream and adder handshake bundle; master = sequencer side.
interface uart_calc_sequencer_if #(
  parameter int DATA_W = uart_calc_pkg::DATA_W_DEF
);
  logic [DATA_W-1:0] rx_tdata;
  logic              rx_tvalid;
  logic              rx_tready;
  logic [DATA_W-1:0] tx_tdata;
  logic              tx_tvalid;
  logic              tx_tready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_start;
  logic [DATA_W:0]   op_result;
  logic              op_done;

  modport master (
    input  rx_tdata, rx_tvalid, tx_tready, op_result, op_done,
    output rx_tready, tx_tdata, tx_tvalid, op_a, op_b, op_start
  );

  modport slave (
    output rx_tdata, rx_tvalid, tx_tready, op_result, op_done,
    input  rx_tready, tx_tdata, tx_tvalid, op_a, op_b, op_start
  );
endinterface

// File: rtl/uart_calc_sequencer_timeout_ctr.sv
// Saturating idle timer: counts 0..LIMIT-1 while enabled, flags expiry, clear wins.
module seq_timeout_ctr
  import uart_calc_pkg::*;
#(
  parameter int LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_calc_sequencer.sv
// Two RX bytes -> adder start/done -> 9-bit sum out as two TX bytes, high first.
// All stream/adder outputs registered; TX holds data under backpressure, RX stalls outside IDLE/WAIT_B.
module uart_calc_sequencer
  import uart_calc_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_calc_sequencer_if.master bus,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      frame_cnt
);
  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic              op_start_q, op_start_d;
  logic [DATA_W:0]   res_q, res_d;
  logic [DATA_W-1:0] tx_tdata_q, tx_tdata_d;
  logic              tx_tvalid_q, tx_tvalid_d;
  logic              timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              rx_xfer, tx_xfer, expired;

  assign bus.rx_tready = (state_q == IDLE) || (state_q == WAIT_B);
  assign bus.tx_tdata  = tx_tdata_q;
  assign bus.tx_tvalid = tx_tvalid_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.op_start  = op_start_q;
  assign busy          = (state_q != IDLE);
  assign timeout_err   = timeout_err_q;
  assign frame_cnt     = frame_cnt_q;

  assign rx_xfer = bus.rx_tvalid && bus.rx_tready;
  assign tx_xfer = tx_tvalid_q && bus.tx_tready;

  // Timer restarts on every state change, so each wait gets a fresh budget.
  seq_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_d != state_q),
    .en_i      ((state_q == WAIT_B) || (state_q == CALC)),
    .expired_o (expired)
  );

  always_comb begin
    state_d       = state_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_start_d    = 1'b0;
    res_d         = res_q;
    tx_tdata_d    = tx_tdata_q;
    tx_tvalid_d   = tx_tvalid_q;
    timeout_err_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (rx_xfer) begin
          op_a_d  = bus.rx_tdata;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_xfer) begin
          op_b_d     = bus.rx_tdata;
          op_start_d = 1'b1;
          state_d    = CALC;
        end else if (expired) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      CALC: begin
        // A done coinciding with our own start pulse cannot belong to this launch.
        if (bus.op_done && !op_start_q) begin
          res_d       = bus.op_result;
          tx_tdata_d  = {{(DATA_W-1){1'b0}}, bus.op_result[DATA_W]};
          tx_tvalid_d = 1'b1;
          state_d     = TX_HI;
        end else if (expired) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      TX_HI: begin
        if (tx_xfer) begin
          tx_tdata_d = res_q[DATA_W-1:0];
          state_d    = TX_LO;
        end else begin
          tx_tdata_d = {{(DATA_W-1){1'b0}}, res_q[DATA_W]};
        end
      end
      TX_LO: begin
        if (tx_xfer) begin
          tx_tvalid_d = 1'b0;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_start_q    <= 1'b0;
      res_q         <= '0;
      tx_tdata_q    <= '0;
      tx_tvalid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_start_q    <= op_start_d;
      res_q         <= res_d;
      tx_tdata_q    <= tx_tdata_d;
      tx_tvalid_q   <= tx_tvalid_d;
      timeout_err_q <= timeout_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end
endmodule

// File: tb/tb_uart_calc_sequencer.sv
// Scoreboard bench: stimulus pushes expected TX bytes, adder launches and aborts; a monitor pops and compares.
module tb_uart_calc_sequencer;
  import uart_calc_pkg::*;

  localparam int DW = 8;
  localparam int TO = 16;
  localparam int CW = 4;

  typedef struct {
    logic [7:0] d;
    bit         hi;
  } tx_exp_t;

  typedef struct {
    logic [7:0] ea;
    logic [7:0] eb;
    int         ecyc;
  } op_exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          busy, timeout_err;
  logic [CW-1:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int adder_mode = 1;
  int adder_lat = 1;
  int late_req = 0;
  int late_ack = 0;

  tx_exp_t exp_tx[$];
  op_exp_t exp_op[$];
  int      exp_to[$];

  logic [31:0] vec [16] = '{
    32'h0000_0000, 32'h01FF_0100, 32'h8080_0100, 32'h7F80_00FF,
    32'hAA55_00FF, 32'hAB55_0100, 32'h1020_0030, 32'hC864_012C,
    32'hFE01_00FF, 32'hFF01_0100, 32'h3C3C_0078, 32'h9999_0132,
    32'hF00F_00FF, 32'hF010_0100, 32'h0100_0001, 32'hE7E7_01CE
  };

  uart_calc_sequencer_if #(.DATA_W(DW)) bus ();

  uart_calc_sequencer #(
    .DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .timeout_err(timeout_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Adder model: normal (latency adder_lat), early (done only in start cycle), or off.
  initial begin : adder
    logic [8:0] s;
    bus.op_done   = 1'b0;
    bus.op_result = '0;
    forever begin
      @(negedge clk);
      if (late_req != late_ack) begin
        late_ack++;
        @(posedge clk); #1;
        bus.op_result = 9'h1FF;
        bus.op_done   = 1'b1;
        @(posedge clk); #1;
        bus.op_done   = 1'b0;
      end else if (bus.op_start && adder_mode == 1) begin
        s = {1'b0, bus.op_a} + {1'b0, bus.op_b};
        repeat (adder_lat) @(posedge clk);
        #1;
        bus.op_result = s;
        bus.op_done   = 1'b1;
        @(posedge clk); #1;
        bus.op_done   = 1'b0;
      end else if (bus.op_start && adder_mode == 2) begin
        bus.op_result = {1'b0, bus.op_a} + {1'b0, bus.op_b};
        bus.op_done   = 1'b1;
        @(posedge clk); #1;
        bus.op_done   = 1'b0;
      end
    end
  end

  bit         prev_stall = 1'b0;
  bit         lo_follow = 1'b0;
  bit         op_prev = 1'b0;
  logic [7:0] prev_dat = '0;

  always @(negedge clk) begin : monitor
    tx_exp_t te;
    op_exp_t oe;
    int      tc;
    if (reset) begin
      prev_stall = 1'b0;
      lo_follow  = 1'b0;
      op_prev    = 1'b0;
    end else begin
      if (prev_stall && bus.tx_tvalid) chk("tx_stable", bus.tx_tdata, prev_dat);
      if (lo_follow) begin
        chk("tx_no_bubble", bus.tx_tvalid, 1);
        lo_follow = 1'b0;
      end
      if (bus.tx_tvalid && bus.tx_tready) begin
        chk("tx_pending", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) begin
          te = exp_tx.pop_front();
          chk(te.hi ? "tx_hi_byte" : "tx_lo_byte", bus.tx_tdata, te.d);
          lo_follow = te.hi;
        end
      end
      prev_stall = bus.tx_tvalid && !bus.tx_tready;
      prev_dat   = bus.tx_tdata;

      if (bus.op_start) begin
        chk("op_start_width", op_prev, 0);
        chk("op_pending", exp_op.size() != 0, 1);
        if (exp_op.size() != 0) begin
          oe = exp_op.pop_front();
          chk("op_a", bus.op_a, oe.ea);
          chk("op_b", bus.op_b, oe.eb);
          chk("op_start_cycle", cyc, oe.ecyc);
        end
      end
      op_prev = bus.op_start;

      if (timeout_err) begin
        chk("to_pending", exp_to.size() != 0, 1);
        if (exp_to.size() != 0) begin
          tc = exp_to.pop_front();
          chk("timeout_cycle", cyc, tc);
        end
      end
    end
  end

  task automatic send_rx(input logic [7:0] b, output int xcyc);
    int n;
    n = 0;
    bus.rx_tdata  = b;
    bus.rx_tvalid = 1'b1;
    @(negedge clk);
    while (!bus.rx_tready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("rx_accept", bus.rx_tready, 1);
    @(posedge clk); #1;
    bus.rx_tvalid = 1'b0;
    xcyc = cyc;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [15:0] sum);
    int ca, cb;
    exp_tx.push_back('{d: sum[15:8], hi: 1'b1});
    exp_tx.push_back('{d: sum[7:0], hi: 1'b0});
    send_rx(a, ca);
    send_rx(b, cb);
    exp_op.push_back('{ea: a, eb: b, ecyc: cb});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_tx.size() != 0 && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("tx_drain", exp_tx.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_tx_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.tx_tvalid && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("tx_valid_seen", bus.tx_tvalid, 1);
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int ca, cb;
    bus.rx_tdata  = '0;
    bus.rx_tvalid = 1'b0;
    bus.tx_tready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_tvalid", bus.tx_tvalid, 0);
    chk("rst_tx_tdata", bus.tx_tdata, 0);
    chk("rst_op_start", bus.op_start, 0);
    chk("rst_op_a", bus.op_a, 0);
    chk("rst_op_b", bus.op_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic frame, adder latency 1
    adder_lat = 1;
    frame(8'h12, 8'h34, 16'h0046);
    wait_drain();
    chk("t1_frame_cnt", frame_cnt, 1);

    // Max sum with TX backpressure for 20 cycles
    bus.tx_tready = 1'b0;
    frame(8'hFF, 8'hFF, 16'h01FE);
    wait_tx_valid();
    repeat (20) @(negedge clk);
    chk("t2_held_hi", bus.tx_tdata, 8'h01);
    @(posedge clk); #1;
    bus.tx_tready = 1'b1;
    wait_drain();
    chk("t2_frame_cnt", frame_cnt, 2);

    // Missing second byte -> abort, then a normal frame
    send_rx(8'h05, ca);
    exp_to.push_back(ca + TO);
    repeat (20) @(negedge clk);
    chk("t3_to_seen", exp_to.size(), 0);
    chk("t3_busy", busy, 0);
    @(posedge clk); #1;
    frame(8'h01, 8'h02, 16'h0003);
    wait_drain();
    chk("t3_frame_cnt", frame_cnt, 3);

    // Adder answers only in the start cycle -> ignored, CALC aborts; late done in IDLE ignored
    adder_mode = 2;
    send_rx(8'h33, ca);
    send_rx(8'h44, cb);
    exp_op.push_back('{ea: 8'h33, eb: 8'h44, ecyc: cb});
    exp_to.push_back(cb + TO);
    repeat (20) @(negedge clk);
    chk("t4_to_seen", exp_to.size(), 0);
    chk("t4_busy", busy, 0);
    @(posedge clk); #1;
    late_req++;
    repeat (6) @(negedge clk);
    chk("t4_late_busy", busy, 0);
    chk("t4_late_tx_tvalid", bus.tx_tvalid, 0);
    chk("t4_frame_cnt", frame_cnt, 3);
    @(posedge clk); #1;
    adder_mode = 1;

    // Reset while the low byte is pending
    bus.tx_tready = 1'b0;
    exp_tx.push_back('{d: 8'h00, hi: 1'b1});
    send_rx(8'h10, ca);
    send_rx(8'h20, cb);
    exp_op.push_back('{ea: 8'h10, eb: 8'h20, ecyc: cb});
    wait_tx_valid();
    @(posedge clk); #1;
    bus.tx_tready = 1'b1;
    @(posedge clk); #1;
    bus.tx_tready = 1'b0;
    chk("t5_pre_tx_tvalid", bus.tx_tvalid, 1);
    chk("t5_pre_tx_tdata", bus.tx_tdata, 8'h30);
    chk("t5_pre_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_tx_tvalid", bus.tx_tvalid, 0);
    chk("t5_tx_tdata", bus.tx_tdata, 0);
    chk("t5_op_a", bus.op_a, 0);
    chk("t5_op_b", bus.op_b, 0);
    chk("t5_busy", busy, 0);
    chk("t5_frame_cnt", frame_cnt, 0);
    reset = 1'b0;
    bus.tx_tready = 1'b1;

    // 16 frames wrap the 4-bit frame counter
    adder_lat = 2;
    for (int i = 0; i < 16; i++) begin
      frame(vec[i][31:24], vec[i][23:16], vec[i][15:0]);
      wait_drain();
      chk("t6_frame_cnt", frame_cnt, (i + 1) % 16);
    end

    repeat (4) @(negedge clk);
    chk("end_op_queue", exp_op.size(), 0);
    chk("end_to_queue", exp_to.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
